// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: requester and BRAM-side signals of the framebuffer arbiter
interface vga_fb_arbiter_if #(parameter int ADDR_W = 16, parameter int DATA_W = 8) ();
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rvalid;
  logic [DATA_W-1:0] rd_rdata;
  logic              blank;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, rd_valid, rd_addr, blank, mem_rdata,
    output disp_rvalid, disp_rdata, wr_ready, rd_ready, rd_rvalid, rd_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data, rd_valid, rd_addr, blank, mem_rdata,
    input  disp_rvalid, disp_rdata, wr_ready, rd_ready, rd_rvalid, rd_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: display-first, writer/reader round-robin arbiter for one single-port framebuffer BRAM
// Define VGA_FB_ARB_BLANK_WRITE_EN to allow draw writes only while blank is high.
module vga_fb_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input logic          clk_100m,
  input logic          rst,
  vga_fb_arbiter_if.slave bus
);
  typedef enum logic {PTR_WR, PTR_RD} ptr_t;
  ptr_t             ptr;
  logic             wr_ok;
  logic             wr_cand;
  logic             contested;
  logic             wr_go;
  logic             rd_go;
  logic             any_go;
  logic [MEM_LAT:0] tag_v;
  logic [MEM_LAT:0] tag_rd;
`ifdef VGA_FB_ARB_BLANK_WRITE_EN
  assign wr_ok = bus.blank;
`else
  logic unused_blank;
  assign unused_blank = bus.blank;
  assign wr_ok = 1'b1;
`endif
  // a stalled writer does not count as contending, so the pointer stays put
  assign wr_cand   = bus.wr_valid && wr_ok;
  assign contested = wr_cand && bus.rd_valid;
  assign wr_go     = !bus.disp_req && wr_cand && (!bus.rd_valid || ptr == PTR_WR);
  assign rd_go     = !bus.disp_req && bus.rd_valid && (!wr_cand || ptr == PTR_RD);
  assign any_go    = bus.disp_req || wr_go || rd_go;
  assign bus.wr_ready = wr_go;
  assign bus.rd_ready = rd_go;
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      ptr             <= PTR_WR;
      tag_v           <= '0;
      tag_rd          <= '0;
      bus.mem_en      <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.disp_rvalid <= 1'b0;
      bus.disp_rdata  <= '0;
      bus.rd_rvalid   <= 1'b0;
      bus.rd_rdata    <= '0;
    end else begin
      if (!bus.disp_req && contested) ptr <= (ptr == PTR_WR) ? PTR_RD : PTR_WR;
      bus.mem_en <= any_go;
      bus.mem_we <= wr_go;
      if (any_go) bus.mem_addr <= bus.disp_req ? bus.disp_addr : wr_go ? bus.wr_addr : bus.rd_addr;
      if (wr_go) bus.mem_wdata <= bus.wr_data;
      // tag stage MEM_LAT lines up with the cycle mem_rdata is valid
      tag_v           <= {tag_v[MEM_LAT-1:0], bus.disp_req || rd_go};
      tag_rd          <= {tag_rd[MEM_LAT-1:0], !bus.disp_req};
      bus.disp_rvalid <= tag_v[MEM_LAT] && !tag_rd[MEM_LAT];
      bus.rd_rvalid   <= tag_v[MEM_LAT] && tag_rd[MEM_LAT];
      if (tag_v[MEM_LAT] && !tag_rd[MEM_LAT]) bus.disp_rdata <= bus.mem_rdata;
      if (tag_v[MEM_LAT] && tag_rd[MEM_LAT]) bus.rd_rdata <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: table-driven arbitration vectors with a response scoreboard and a BRAM model
module tb_vga_fb_arbiter;
  localparam int ADDR_W = 16, DATA_W = 8, MEM_LAT = 1;
  logic clk_100m = 1'b0;
  logic rst = 1'b1;
  always #5 clk_100m = ~clk_100m;
  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();
  vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk_100m(clk_100m), .rst(rst), .bus(ifc));
  typedef struct {
    logic disp; logic [15:0] daddr;
    logic wv; logic [15:0] waddr; logic [7:0] wdata;
    logic rv; logic [15:0] raddr;
    logic blank; logic ewr; logic erd;
  } vec_t;
  typedef struct { logic rd; logic [7:0] data; int due; } rsp_t;
  rsp_t sb[$];
  vec_t tbl[$];
  logic [7:0] shadow[int];
  logic [7:0] bram [0:65535];
  bit bram_w [0:65535];
  int cyc = 0, n_cmp = 0, n_fail = 0;
  logic pen = 1'b0, pwe = 1'b0;
  logic [15:0] paddr = '0;
  logic [7:0] pwd = '0;
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ 8'hB5;
  endfunction
  function automatic logic [7:0] sh_rd(input logic [15:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(a);
  endfunction
  function automatic vec_t V(input int d, input int da, input int wv, input int wa, input int wd,
                             input int rv, input int ra, input int bl, input int ew, input int er);
    vec_t r;
    r.disp = d[0]; r.daddr = da[15:0]; r.wv = wv[0]; r.waddr = wa[15:0]; r.wdata = wd[7:0];
    r.rv = rv[0]; r.raddr = ra[15:0]; r.blank = bl[0]; r.ewr = ew[0]; r.erd = er[0];
    return r;
  endfunction
  always @(posedge clk_100m) cyc <= cyc + 1;
  // write-first single-port BRAM, one cycle read latency
  always @(posedge clk_100m) begin
    if (ifc.mem_en) begin
      ifc.mem_rdata <= ifc.mem_we ? ifc.mem_wdata
                     : (bram_w[ifc.mem_addr] ? bram[ifc.mem_addr] : init_val(ifc.mem_addr));
      if (ifc.mem_we) begin
        bram[ifc.mem_addr]   <= ifc.mem_wdata;
        bram_w[ifc.mem_addr] <= 1'b1;
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    ifc.disp_req = v.disp; ifc.disp_addr = v.daddr;
    ifc.wr_valid = v.wv; ifc.wr_addr = v.waddr; ifc.wr_data = v.wdata;
    ifc.rd_valid = v.rv; ifc.rd_addr = v.raddr; ifc.blank = v.blank;
  endtask
  task automatic mon();
    rsp_t e;
    logic gv, ov;
    logic [7:0] gd;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      gv = e.rd ? ifc.rd_rvalid : ifc.disp_rvalid;
      ov = e.rd ? ifc.disp_rvalid : ifc.rd_rvalid;
      gd = e.rd ? ifc.rd_rdata : ifc.disp_rdata;
      n_cmp++;
      if (!gv || ov || gd !== e.data) begin
        n_fail++;
        $display("FAIL rsp %s @%0d: rvalid=%0b other=%0b data=%h want rvalid=1 other=0 data=%h",
                 e.rd ? "rd" : "disp", cyc, gv, ov, gd, e.data);
      end
    end else if (ifc.disp_rvalid || ifc.rd_rvalid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL spurious rvalid @%0d: disp=%0b rd=%0b want 0 0", cyc, ifc.disp_rvalid, ifc.rd_rvalid);
    end
  endtask
  task automatic step(input vec_t v, input string nm);
    @(posedge clk_100m);
    #1;
    drive(v);
    #3;
    chk({nm, " wr_ready"}, 32'(ifc.wr_ready), 32'(v.ewr));
    chk({nm, " rd_ready"}, 32'(ifc.rd_ready), 32'(v.erd));
    chk({nm, " mem_en"}, 32'(ifc.mem_en), 32'(pen));
    if (pen) begin
      chk({nm, " mem_we"}, 32'(ifc.mem_we), 32'(pwe));
      chk({nm, " mem_addr"}, 32'(ifc.mem_addr), 32'(paddr));
    end
    if (pwe) chk({nm, " mem_wdata"}, 32'(ifc.mem_wdata), 32'(pwd));
    pen = v.disp | v.ewr | v.erd;
    pwe = !v.disp & v.ewr;
    paddr = v.disp ? v.daddr : v.ewr ? v.waddr : v.raddr;
    pwd = v.wdata;
    if (v.disp) sb.push_back('{1'b0, sh_rd(v.daddr), cyc + 2 + MEM_LAT});
    else if (v.erd) sb.push_back('{1'b1, sh_rd(v.raddr), cyc + 2 + MEM_LAT});
    else if (v.ewr) shadow[int'(v.waddr)] = v.wdata;
    @(negedge clk_100m);
    mon();
  endtask
  task automatic chk_outs_zero(input string nm);
    chk({nm, " mem_en"}, 32'(ifc.mem_en), 0);
    chk({nm, " mem_we"}, 32'(ifc.mem_we), 0);
    chk({nm, " mem_addr"}, 32'(ifc.mem_addr), 0);
    chk({nm, " mem_wdata"}, 32'(ifc.mem_wdata), 0);
    chk({nm, " rvalids"}, 32'({ifc.disp_rvalid, ifc.rd_rvalid}), 0);
    chk({nm, " disp_rdata"}, 32'(ifc.disp_rdata), 0);
    chk({nm, " rd_rdata"}, 32'(ifc.rd_rdata), 0);
    chk({nm, " readies"}, 32'({ifc.wr_ready, ifc.rd_ready}), 0);
  endtask
  initial begin
    vec_t idle;
    idle = V(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(idle);
    repeat (2) @(posedge clk_100m);
    #2;
    chk_outs_zero("reset");
    rst = 1'b0;
    //        disp daddr   wv waddr   wdata rv raddr   bl ewr erd
    tbl.push_back(V(0, 0,      0, 0,      0,    0, 0,      1, 0, 0));
    tbl.push_back(V(1, 'h0010, 0, 0,      0,    0, 0,      1, 0, 0));
    tbl.push_back(idle); tbl.push_back(idle);
    tbl.push_back(V(1, 'h0020, 1, 'h0100, 'h11, 1, 'h0200, 1, 0, 0));
    tbl.push_back(V(0, 0,      1, 'h0100, 'h11, 1, 'h0200, 1, 1, 0));
    tbl.push_back(V(0, 0,      1, 'h0101, 'h22, 1, 'h0200, 1, 0, 1));
    tbl.push_back(V(0, 0,      1, 'h0300, 'hA1, 1, 'h0300, 1, 1, 0));
    tbl.push_back(V(0, 0,      1, 'h0301, 'hA2, 1, 'h0300, 1, 0, 1));
    tbl.push_back(V(0, 0,      1, 'h0301, 'hA2, 1, 'h0301, 1, 1, 0));
    tbl.push_back(V(0, 0,      1, 'h0302, 'hA3, 1, 'h0301, 1, 0, 1));
    tbl.push_back(V(0, 0,      1, 'h0302, 'hA3, 1, 'h0302, 1, 1, 0));
    tbl.push_back(V(0, 0,      1, 'h0303, 'hA4, 1, 'h0302, 1, 0, 1));
    tbl.push_back(V(0, 0,      1, 'h1234, 'h3C, 0, 0,      1, 1, 0));
    tbl.push_back(V(0, 0,      0, 0,      0,    1, 'h1234, 1, 0, 1));
    tbl.push_back(V(0, 0,      0, 0,      0,    1, 'h0010, 1, 0, 1));
    tbl.push_back(V(1, 'h0011, 0, 0,      0,    0, 0,      1, 0, 0));
    tbl.push_back(V(1, 'h0012, 0, 0,      0,    1, 'h0500, 1, 0, 0));
    tbl.push_back(V(0, 0,      1, 'h0400, 'h55, 1, 'h0500, 1, 1, 0));
    tbl.push_back(V(0, 0,      1, 'h0401, 'h66, 0, 0,      1, 1, 0));
    tbl.push_back(V(0, 0,      1, 'h0402, 'h77, 1, 'h0401, 1, 0, 1));
    tbl.push_back(V(0, 0,      1, 'hFFFF, 'hEE, 0, 0,      1, 1, 0));
    tbl.push_back(V(0, 0,      0, 0,      0,    1, 'hFFFF, 1, 0, 1));
    tbl.push_back(V(1, 'h0000, 0, 0,      0,    0, 0,      1, 0, 0));
    tbl.push_back(idle); tbl.push_back(idle); tbl.push_back(idle);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("v%0d", i));
`ifdef VGA_FB_ARB_BLANK_WRITE_EN
    for (int i = 0; i < 10; i++) step(V(0, 0, 1, 'h0600, 'h99, 0, 0, 0, 0, 0), $sformatf("stall%0d", i));
    step(V(0, 0, 1, 'h0600, 'h99, 0, 0,      1, 1, 0), "blank_rise");
    step(V(0, 0, 1, 'h0601, 'h98, 1, 'h0601, 0, 0, 1), "visible_contest");
    step(V(0, 0, 1, 'h0601, 'h98, 1, 'h0601, 1, 1, 0), "ptr_kept");
`else
    step(V(0, 0, 1, 'h0600, 'h99, 1, 'h0601, 0, 1, 0), "blank_ignored");
    step(V(0, 0, 1, 'h0601, 'h98, 1, 'h0600, 1, 0, 1), "ptr_flipped");
`endif
    step(idle, "pre_rst");
    step(V(1, 'h0040, 0, 0, 0, 0, 0, 1, 0, 0), "rst_disp");
    drive(idle);
    @(posedge clk_100m);
    #2;
    rst = 1'b1;
    #1;
    chk_outs_zero("async_rst");
    sb.delete();
    pen = 1'b0;
    pwe = 1'b0;
    repeat (2) @(posedge clk_100m);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(idle, $sformatf("post_rst%0d", i));
      chk("post_rst rvalids", 32'({ifc.disp_rvalid, ifc.rd_rvalid}), 0);
    end
    step(V(0, 0, 1, 'h0700, 'hC3, 1, 'h0700, 1, 1, 0), "rst_ptr");
    step(V(0, 0, 0, 0,      0,    1, 'h0700, 1, 0, 1), "rd_after_rst");
    for (int i = 0; i < 4; i++) step(idle, "drain");
    chk("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
